// File: rtl/branch_pkg.sv
// rtl/branch_pkg.sv - branch op codes, 2-bit counter states and saturating update helper
package branch_pkg;

    localparam logic [4:0] BR_NONE = 5'b00000;
    localparam logic [4:0] BR_BEQ  = 5'b01000;
    localparam logic [4:0] BR_BNE  = 5'b01001;
    localparam logic [4:0] BR_BLT  = 5'b01100;
    localparam logic [4:0] BR_BGE  = 5'b01101;
    localparam logic [4:0] BR_BLTU = 5'b01110;
    localparam logic [4:0] BR_BGEU = 5'b01111;
    localparam logic [4:0] BR_JUMP = 5'b11111;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_e;

    // Saturating 2-bit counter step: toward ST when taken, toward SNT otherwise.
    function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
        logic [1:0] res;
        if (taken) begin
            res = (ctr == ST) ? ST : ctr + 2'd1;
        end else begin
            res = (ctr == SNT) ? SNT : ctr - 2'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/bht_2bit.sv
// rtl/bht_2bit.sv - 2-bit saturating counter table, async read, sync update, async reset
module bht_2bit
    import branch_pkg::*;
#(
    parameter int         DEPTH    = 64,
    parameter logic [1:0] CTR_INIT = 2'b01,
    localparam int        IDX      = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [IDX-1:0] rd_idx,
    output logic [1:0]     rd_ctr,
    input  logic           wr_en,
    input  logic [IDX-1:0] wr_idx,
    input  logic           wr_taken
);

    logic [1:0] mem [DEPTH];

    // Read is purely combinational; a same-cycle write is only visible after the edge.
    assign rd_ctr = mem[rd_idx];

    // Counter update at the clock edge; reset returns every entry to CTR_INIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= CTR_INIT;
            end
        end else if (wr_en) begin
            mem[wr_idx] <= ctr_next(mem[wr_idx], wr_taken);
        end
    end

endmodule

// File: rtl/branch_predict_resolve.sv
// rtl/branch_predict_resolve.sv - EX branch resolve, BHT predictor, redirect; option macro BRANCH_PERF_EN
module branch_predict_resolve
    import branch_pkg::*;
#(
    parameter int         XLEN      = 32,
    parameter int         BHT_DEPTH = 64,
    parameter logic [1:0] CTR_INIT  = 2'b01
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] if_pc,
    output logic            if_pred_taken,
    input  logic            ex_valid,
    input  logic            ex_flush,
    input  logic [4:0]      ex_brop,
    input  logic [XLEN-1:0] ex_rs1,
    input  logic [XLEN-1:0] ex_rs2,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_target,
    input  logic            ex_pred_taken,
    output logic            ex_taken,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic [31:0]     perf_branches,
    output logic [31:0]     perf_mispred
);

    localparam int IDX = $clog2(BHT_DEPTH);

    logic            is_cond;
    logic            is_jump;
    logic            cond_taken;
    logic            qual;
    logic            mispred;
    logic            redirect_next;
    logic [XLEN-1:0] next_pc;
    logic [1:0]      rd_ctr;

    // Decode the branch op and evaluate the rs1 OP rs2 compare; unknown codes behave as none.
    always_comb begin
        is_cond    = 1'b0;
        is_jump    = 1'b0;
        cond_taken = 1'b0;
        case (ex_brop)
            BR_BEQ:  begin is_cond = 1'b1; cond_taken = (ex_rs1 == ex_rs2); end
            BR_BNE:  begin is_cond = 1'b1; cond_taken = (ex_rs1 != ex_rs2); end
            BR_BLT:  begin is_cond = 1'b1; cond_taken = ($signed(ex_rs1) <  $signed(ex_rs2)); end
            BR_BGE:  begin is_cond = 1'b1; cond_taken = ($signed(ex_rs1) >= $signed(ex_rs2)); end
            BR_BLTU: begin is_cond = 1'b1; cond_taken = (ex_rs1 <  ex_rs2); end
            BR_BGEU: begin is_cond = 1'b1; cond_taken = (ex_rs1 >= ex_rs2); end
            BR_JUMP: is_jump = 1'b1;
            default: ;
        endcase
    end

    // The instruction behind a redirect is wrong-path shadow and must not act.
    assign qual          = ex_valid & ~ex_flush & ~redirect_valid;
    assign ex_taken      = qual & (is_jump | (is_cond & cond_taken));
    assign mispred       = qual & is_cond & (cond_taken ^ ex_pred_taken);
    assign redirect_next = mispred | (qual & is_jump);
    assign next_pc       = ex_taken ? ex_target : ex_pc + XLEN'(4);

    // One-cycle redirect pulse; the PC holds its last value while no redirect is pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
        end else begin
            redirect_valid <= redirect_next;
            if (redirect_next) begin
                redirect_pc <= next_pc;
            end
        end
    end

    bht_2bit #(
        .DEPTH    (BHT_DEPTH),
        .CTR_INIT (CTR_INIT)
    ) u_bht (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_idx   (if_pc[IDX+1:2]),
        .rd_ctr   (rd_ctr),
        .wr_en    (qual & is_cond),
        .wr_idx   (ex_pc[IDX+1:2]),
        .wr_taken (cond_taken)
    );

    assign if_pred_taken = rd_ctr[1];

    // PC bits outside the index and the counter's low bit are deliberately ignored.
    logic unused_bits;
    assign unused_bits = ^{if_pc[XLEN-1:IDX+2], if_pc[1:0], rd_ctr[0]};

`ifdef BRANCH_PERF_EN
    logic [31:0] branches_q;
    logic [31:0] mispred_q;

    // Saturating event counters for qualified conditional branches and their mispredictions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branches_q <= '0;
            mispred_q  <= '0;
        end else begin
            if (qual && is_cond && branches_q != 32'hFFFF_FFFF) begin
                branches_q <= branches_q + 32'd1;
            end
            if (mispred && mispred_q != 32'hFFFF_FFFF) begin
                mispred_q <= mispred_q + 32'd1;
            end
        end
    end

    assign perf_branches = branches_q;
    assign perf_mispred  = mispred_q;
`else
    assign perf_branches = '0;
    assign perf_mispred  = '0;
`endif

endmodule

// File: tb/tb_branch_predict_resolve.sv
// tb/tb_branch_predict_resolve.sv - self-checking bench for branch_predict_resolve
module tb_branch_predict_resolve;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] if_pc;
    logic        if_pred_taken;
    logic        ex_valid;
    logic        ex_flush;
    logic [4:0]  ex_brop;
    logic [31:0] ex_rs1;
    logic [31:0] ex_rs2;
    logic [31:0] ex_pc;
    logic [31:0] ex_target;
    logic        ex_pred_taken;
    logic        ex_taken;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] perf_branches;
    logic [31:0] perf_mispred;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    branch_predict_resolve dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .if_pc          (if_pc),
        .if_pred_taken  (if_pred_taken),
        .ex_valid       (ex_valid),
        .ex_flush       (ex_flush),
        .ex_brop        (ex_brop),
        .ex_rs1         (ex_rs1),
        .ex_rs2         (ex_rs2),
        .ex_pc          (ex_pc),
        .ex_target      (ex_target),
        .ex_pred_taken  (ex_pred_taken),
        .ex_taken       (ex_taken),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .perf_branches  (perf_branches),
        .perf_mispred   (perf_mispred)
    );

    typedef struct {
        string       name;
        logic [4:0]  brop;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] pc;
        logic [31:0] target;
        logic        pred;
        logic        valid;
        logic        flush;
        logic        exp_taken;
        logic        exp_redir;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [4:0] brop, input logic [31:0] rs1, input logic [31:0] rs2,
                         input logic [31:0] pc, input logic [31:0] target, input logic pred,
                         input logic valid, input logic flush);
        ex_brop       = brop;
        ex_rs1        = rs1;
        ex_rs2        = rs2;
        ex_pc         = pc;
        ex_target     = target;
        ex_pred_taken = pred;
        ex_valid      = valid;
        ex_flush      = flush;
    endtask

    task automatic idle();
        drive(5'b00000, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #3;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        vecs[0] = '{"blt_signed",   5'b01100, 32'hFFFF_FFFF, 32'd1, 32'h380, 32'h900,  1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h900};
        vecs[1] = '{"bltu_unsigned",5'b01110, 32'hFFFF_FFFF, 32'd1, 32'h380, 32'h900,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
        vecs[2] = '{"bge_signed",   5'b01101, 32'hFFFF_FFFF, 32'd1, 32'h380, 32'h900,  1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h384};
        vecs[3] = '{"bgeu_unsigned",5'b01111, 32'hFFFF_FFFF, 32'd1, 32'h380, 32'h900,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0};
        vecs[4] = '{"beq_equal",    5'b01000, 32'd5,         32'd5, 32'h380, 32'h900,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0};
        vecs[5] = '{"bne_equal",    5'b01001, 32'd5,         32'd5, 32'h380, 32'h900,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
        vecs[6] = '{"jump",         5'b11111, 32'd0,         32'd0, 32'h380, 32'h8000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h8000};
        vecs[7] = '{"jump_flush",   5'b11111, 32'd0,         32'd0, 32'h380, 32'h8000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0};
        vecs[8] = '{"illegal_op",   5'b10101, 32'd5,         32'd5, 32'h380, 32'h900,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
        vecs[9] = '{"beq_invalid",  5'b01000, 32'd5,         32'd5, 32'h380, 32'h900,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};

        rst_n = 1'b0;
        if_pc = 32'h100;
        idle();
        #2;
        check("rst_redirect_valid", {31'd0, redirect_valid}, 32'd0);
        check("rst_redirect_pc", redirect_pc, 32'd0);
        check("rst_pred", {31'd0, if_pred_taken}, 32'd0);
        check("rst_perf_branches", perf_branches, 32'd0);
        check("rst_perf_mispred", perf_mispred, 32'd0);
        #10;
        rst_n = 1'b1;
        tick();

        // Table: compare signs, jump, flush, illegal code, invalid slot.
        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].brop, vecs[i].rs1, vecs[i].rs2, vecs[i].pc, vecs[i].target,
                  vecs[i].pred, vecs[i].valid, vecs[i].flush);
            #1;
            check({vecs[i].name, "_taken"}, {31'd0, ex_taken}, {31'd0, vecs[i].exp_taken});
            tick();
            check({vecs[i].name, "_redir"}, {31'd0, redirect_valid}, {31'd0, vecs[i].exp_redir});
            if (vecs[i].exp_redir) begin
                check({vecs[i].name, "_redir_pc"}, redirect_pc, vecs[i].exp_pc);
            end
            idle();
            tick();
            check({vecs[i].name, "_pulse_end"}, {31'd0, redirect_valid}, 32'd0);
        end

        // Training at 0x100 from WNT: predictions 0,1,1,1 and a mispredict only on the first.
        do_reset();
        if_pc = 32'h100;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("train_pred_%0d", i), {31'd0, if_pred_taken}, {31'd0, (i != 0)});
            drive(5'b01000, 32'd7, 32'd7, 32'h100, 32'h600, (i != 0), 1'b1, 1'b0);
            tick();
            check($sformatf("train_redir_%0d", i), {31'd0, redirect_valid}, {31'd0, (i == 0)});
            idle();
            tick();
        end
        // Saturated at ST: one not-taken leaves WT (still taken), a second gives WNT.
        for (int i = 0; i < 2; i++) begin
            drive(5'b01000, 32'd7, 32'd8, 32'h100, 32'h600, 1'b1, 1'b1, 1'b0);
            tick();
            idle();
            tick();
            check($sformatf("train_dec_pred_%0d", i), {31'd0, if_pred_taken}, {31'd0, (i == 0)});
        end

        // Mispredicted BNE, then a would-be mispredict in the shadow cycle is ignored.
        drive(5'b01001, 32'd3, 32'd3, 32'h200, 32'h700, 1'b1, 1'b1, 1'b0);
        tick();
        check("bne_redir", {31'd0, redirect_valid}, 32'd1);
        check("bne_redir_pc", redirect_pc, 32'h204);
        drive(5'b01000, 32'd1, 32'd1, 32'h380, 32'h900, 1'b0, 1'b1, 1'b0);
        #1;
        check("shadow_taken", {31'd0, ex_taken}, 32'd0);
        tick();
        check("shadow_redir", {31'd0, redirect_valid}, 32'd0);
        idle();
        if_pc = 32'h380;
        #1;
        check("shadow_no_update", {31'd0, if_pred_taken}, 32'd0);

        // Jump at 0x40 must not touch the BHT entry.
        drive(5'b11111, 32'd0, 32'd0, 32'h40, 32'h8000, 1'b0, 1'b1, 1'b0);
        tick();
        check("jump_redir", {31'd0, redirect_valid}, 32'd1);
        check("jump_redir_pc", redirect_pc, 32'h8000);
        idle();
        tick();
        if_pc = 32'h40;
        #1;
        check("jump_bht_unchanged", {31'd0, if_pred_taken}, 32'd0);

        // Bring 0x40 to WT, then read and write it in the same cycle.
        drive(5'b01000, 32'd2, 32'd2, 32'h40, 32'h500, 1'b0, 1'b1, 1'b0);
        tick();
        idle();
        tick();
        drive(5'b01001, 32'd3, 32'd3, 32'h40, 32'h500, 1'b1, 1'b1, 1'b0);
        #1;
        check("rw_same_cycle_old", {31'd0, if_pred_taken}, 32'd1);
        tick();
        check("rw_next_cycle_new", {31'd0, if_pred_taken}, 32'd0);
        check("rw_redir_pc", redirect_pc, 32'h44);
        idle();
        tick();

        // Asynchronous reset in the middle of a redirect pulse.
        drive(5'b11111, 32'd0, 32'd0, 32'h60, 32'h8000, 1'b0, 1'b1, 1'b0);
        tick();
        check("pre_reset_redir", {31'd0, redirect_valid}, 32'd1);
        idle();
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_redir", {31'd0, redirect_valid}, 32'd0);
        check("async_reset_pc", redirect_pc, 32'd0);
        if_pc = 32'h100;
        #1;
        check("reset_pred_100", {31'd0, if_pred_taken}, 32'd0);
        if_pc = 32'h40;
        #1;
        check("reset_pred_40", {31'd0, if_pred_taken}, 32'd0);
        tick();
        rst_n = 1'b1;
        // WNT (not SNT): a single taken branch flips the prediction.
        drive(5'b01000, 32'd1, 32'd1, 32'h40, 32'h500, 1'b0, 1'b1, 1'b0);
        tick();
        idle();
        tick();
        check("reset_is_wnt", {31'd0, if_pred_taken}, 32'd1);

        // Performance counters: 5 branches, 2 mispredictions after reset.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            case (i)
                3:       drive(5'b01001, 32'd4, 32'd4, 32'h380, 32'h900, 1'b1, 1'b1, 1'b0);
                4:       drive(5'b01000, 32'd4, 32'd4, 32'h380, 32'h900, 1'b0, 1'b1, 1'b0);
                default: drive(5'b01000, 32'd4, 32'd4, 32'h380, 32'h900, 1'b1, 1'b1, 1'b0);
            endcase
            tick();
            idle();
            tick();
        end
`ifdef BRANCH_PERF_EN
        check("perf_branches", perf_branches, 32'd5);
        check("perf_mispred", perf_mispred, 32'd2);
`else
        check("perf_branches_tied", perf_branches, 32'd0);
        check("perf_mispred_tied", perf_mispred, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
